// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcode constants, the idle instruction word and
// the fetch stage state type. The control unit imports the same constants.
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_I      = 7'd19;
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;

    // addi x0,x0,0 -- what the instruction register shows while nothing is valid
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        VALID,
        ERR
    } fetch_state_t;

    // A byte address can be fetched only if it points at a 32-bit word boundary
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_rv32i.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a
// req/gnt/rvalid handshake with a single outstanding request, and holds the
// instruction and its decoded fields until the core retires it.
module fetch_unit_rv32i
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7_bit5,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        misalign_err
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic         imem_req_q, imem_req_d;
    logic         misalign_err_q, misalign_err_d;

    // Next-state and next-output logic; outputs are computed one cycle ahead so they leave the block registered
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        instr_valid_d  = instr_valid_q;
        imem_req_d     = imem_req_q;
        misalign_err_d = misalign_err_q;

        case (state_q)
            IDLE: begin
                state_d    = FETCH;
                imem_req_d = 1'b1;
            end
            FETCH: begin
                if (imem_gnt) begin
                    state_d    = WAIT;
                    imem_req_d = 1'b0;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = VALID;
                end
            end
            VALID: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    if (PCSrc && !is_word_aligned(PCTarget)) begin
                        misalign_err_d = 1'b1;
                        state_d        = ERR;
                    end else begin
                        pc_d       = PCSrc ? PCTarget : pc_plus4;
                        imem_req_d = 1'b1;
                        state_d    = FETCH;
                    end
                end
            end
            ERR: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
            default: begin
                state_d       = IDLE;
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            instr_q        <= NOP_INSTR;
            instr_valid_q  <= 1'b0;
            imem_req_q     <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            instr_valid_q  <= instr_valid_d;
            imem_req_q     <= imem_req_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign imem_req     = imem_req_q;
    assign imem_addr    = pc_q;
    assign instr_valid  = instr_valid_q;
    assign instr        = instr_q;
    assign pc           = pc_q;
    assign misalign_err = misalign_err_q;

    assign pc_plus4     = pc_q + 32'd4;
    assign op           = instr_q[6:0];
    assign funct3       = instr_q[14:12];
    assign funct7_bit5  = instr_q[30];
    assign rs1          = instr_q[19:15];
    assign rs2          = instr_q[24:20];
    assign rd           = instr_q[11:7];

endmodule

// File: tb/tb_fetch_unit_rv32i.sv
// Self-checking bench for fetch_unit_rv32i. A second instance with the reset
// PC at the top of the address space shares every input with the main one.
module tb_fetch_unit_rv32i;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_gnt, imem_rvalid, instr_ready, pcsrc;
    logic [31:0] imem_rdata, pctarget;

    logic        imem_req, instr_valid, funct7_bit5, misalign_err;
    logic [31:0] imem_addr, instr, pc, pc_plus4;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;

    logic        h_imem_req, h_instr_valid, h_funct7_bit5, h_misalign_err;
    logic [31:0] h_imem_addr, h_instr, h_pc, h_pc_plus4;
    logic [6:0]  h_op;
    logic [2:0]  h_funct3;
    logic [4:0]  h_rs1, h_rs2, h_rd;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] model_pc;

    always #5 clk = ~clk;

    fetch_unit_rv32i dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .PCSrc(pcsrc), .PCTarget(pctarget),
        .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .op(op), .funct3(funct3),
        .funct7_bit5(funct7_bit5), .rs1(rs1), .rs2(rs2), .rd(rd),
        .misalign_err(misalign_err)
    );

    fetch_unit_rv32i #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
        .clk(clk), .rst_n(rst_n),
        .imem_req(h_imem_req), .imem_addr(h_imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(h_instr_valid), .instr_ready(instr_ready),
        .PCSrc(pcsrc), .PCTarget(pctarget),
        .instr(h_instr), .pc(h_pc), .pc_plus4(h_pc_plus4), .op(h_op), .funct3(h_funct3),
        .funct7_bit5(h_funct7_bit5), .rs1(h_rs1), .rs2(h_rs2), .rd(h_rd),
        .misalign_err(h_misalign_err)
    );

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Act as instruction memory for one request: wait for req, stall gnt, then stall rvalid
    task automatic do_fetch(input int gnt_delay, input int rvalid_delay, input logic [31:0] data,
                            input bit junk, output bit found, output bit stable,
                            output logic [31:0] addr);
        int n;
        found  = 1'b0;
        stable = 1'b1;
        addr   = 32'hDEAD_BEEF;
        n = 0;
        while (imem_req !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        if (imem_req !== 1'b1) return;
        found = 1'b1;
        addr  = imem_addr;
        for (int i = 0; i < gnt_delay; i++) begin
            imem_rvalid = junk;
            imem_rdata  = $urandom;
            instr_ready = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            pcsrc       = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            pctarget    = $urandom;
            tick();
            if (imem_req !== 1'b1 || imem_addr !== addr || instr_valid !== 1'b0) stable = 1'b0;
        end
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b1;
        tick();
        imem_gnt = 1'b0;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) stable = 1'b0;
        for (int i = 0; i < rvalid_delay; i++) begin
            instr_ready = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            pcsrc       = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            pctarget    = $urandom;
            tick();
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) stable = 1'b0;
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        instr_ready = 1'b0;
        pcsrc       = 1'b0;
    endtask

    // Retire the current instruction with the given redirect
    task automatic retire(input bit src, input logic [31:0] tgt);
        instr_ready = 1'b1;
        pcsrc       = src;
        pctarget    = tgt;
        tick();
        instr_ready = 1'b0;
        pcsrc       = 1'b0;
        pctarget    = $urandom;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; pcsrc = 1'b0; pctarget = '0;
        tick();
        tick();
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_req got %b expected 0", imem_req); end
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got %b expected 0", instr_valid); end
        tests_run++; if (misalign_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err got %b expected 0", misalign_err); end
        tests_run++; if (pc !== 32'h0 || imem_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_pc got %h/%h expected 0", pc, imem_addr); end
        tests_run++; if (instr !== 32'h0000_0013) begin tests_failed++; $display("[TB] FAIL reset_instr got %h expected 00000013", instr); end
        tests_run++; if (h_pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("[TB] FAIL reset_pc_hi got %h expected fffffffc", h_pc); end
        rst_n = 1'b1;
        model_pc = 32'h0;
    endtask

    task automatic test_first_fetch();
        bit found, stable;
        logic [31:0] addr;
        do_fetch(0, 0, 32'h0000_0033, 1'b0, found, stable, addr);
        tests_run++; if (!found) begin tests_failed++; $display("[TB] FAIL first_req_timeout got none expected req"); end
        tests_run++; if (addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL first_addr got %h expected 0", addr); end
        tests_run++; if (!stable) begin tests_failed++; $display("[TB] FAIL first_handshake got unstable expected stable"); end
        tests_run++; if (instr_valid !== 1'b1 || op !== OP_R) begin tests_failed++; $display("[TB] FAIL first_valid got v=%b op=%0d expected v=1 op=51", instr_valid, op); end
    endtask

    task automatic test_sequential();
        bit found, stable;
        logic [31:0] addr, data;
        for (int k = 0; k < 3; k++) begin
            retire(1'b0, $urandom);
            model_pc = model_pc + 32'd4;
            data = $urandom;
            do_fetch(0, 0, data, 1'b0, found, stable, addr);
            tests_run++; if (!found || addr !== model_pc) begin tests_failed++; $display("[TB] FAIL seq_addr got %h expected %h", addr, model_pc); end
            tests_run++; if (pc !== model_pc || pc_plus4 !== model_pc + 32'd4) begin tests_failed++; $display("[TB] FAIL seq_pc got %h/%h expected %h", pc, pc_plus4, model_pc); end
            tests_run++; if (instr !== data || rd !== data[11:7] || rs1 !== data[19:15]) begin tests_failed++; $display("[TB] FAIL seq_instr got %h expected %h", instr, data); end
        end
    endtask

    task automatic test_redirect();
        bit found, stable;
        logic [31:0] addr, data;
        retire(1'b1, 32'h8);
        model_pc = 32'h8;
        data = $urandom;
        do_fetch(0, 0, data, 1'b0, found, stable, addr);
        tests_run++; if (!found || addr !== 32'h8 || pc !== 32'h8) begin tests_failed++; $display("[TB] FAIL redir_back got %h/%h expected 00000008", addr, pc); end
        retire(1'b1, 32'h100);
        model_pc = 32'h100;
        tests_run++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL redir_addr got %h req=%b expected 00000100", imem_addr, imem_req); end
        do_fetch(0, 0, data, 1'b0, found, stable, addr);
        tests_run++; if (pc !== 32'h100 || instr_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL redir_pc got %h v=%b expected 00000100", pc, instr_valid); end
    endtask

    task automatic test_backpressure();
        bit found, stable, held, req_seen;
        logic [31:0] addr, data;
        retire(1'b0, 32'h0);
        model_pc = model_pc + 32'd4;
        data = $urandom;
        do_fetch(3, 2, data, 1'b1, found, stable, addr);
        tests_run++; if (!found || !stable || addr !== model_pc) begin tests_failed++; $display("[TB] FAIL bp_stall got f=%b s=%b %h expected %h", found, stable, addr, model_pc); end
        held = 1'b1;
        req_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pcsrc    = 1'($urandom_range(0, 1));
            pctarget = $urandom;
            tick();
            if (instr !== data || pc !== model_pc || instr_valid !== 1'b1 ||
                op !== data[6:0] || funct3 !== data[14:12] || rs2 !== data[24:20]) held = 1'b0;
            if (imem_req !== 1'b0) req_seen = 1'b1;
        end
        pcsrc = 1'b0;
        tests_run++; if (!held) begin tests_failed++; $display("[TB] FAIL bp_hold got %h pc=%h expected %h pc=%h", instr, pc, data, model_pc); end
        tests_run++; if (req_seen) begin tests_failed++; $display("[TB] FAIL bp_extra_req got req expected none"); end
    endtask

    task automatic test_random();
        bit found, stable, src;
        logic [31:0] addr, data, tgt;
        for (int k = 0; k < 16; k++) begin
            src = 1'($urandom_range(0, 1));
            tgt = (k == 5) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            retire(src, tgt);
            model_pc = src ? tgt : model_pc + 32'd4;
            data = $urandom;
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3), data, 1'b1, found, stable, addr);
            tests_run++; if (!found || !stable || addr !== model_pc) begin tests_failed++; $display("[TB] FAIL rnd_addr got %h s=%b expected %h", addr, stable, model_pc); end
            tests_run++; if (pc !== model_pc || pc_plus4 !== model_pc + 32'd4) begin tests_failed++; $display("[TB] FAIL rnd_pc got %h/%h expected %h", pc, pc_plus4, model_pc); end
            tests_run++;
            if (instr_valid !== 1'b1 || instr !== data || op !== data[6:0] || funct3 !== data[14:12] ||
                funct7_bit5 !== data[30] || rs1 !== data[19:15] || rs2 !== data[24:20] || rd !== data[11:7]) begin
                tests_failed++; $display("[TB] FAIL rnd_fields got %h v=%b expected %h", instr, instr_valid, data);
            end
        end
    endtask

    task automatic test_misalign();
        bit stuck;
        logic [31:0] saved;
        saved = model_pc;
        retire(1'b1, 32'h102);
        tests_run++; if (misalign_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL mis_err got %b expected 1", misalign_err); end
        tests_run++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== saved) begin tests_failed++; $display("[TB] FAIL mis_state got req=%b v=%b pc=%h expected 0/0/%h", imem_req, instr_valid, pc, saved); end
        stuck = 1'b1;
        for (int i = 0; i < 6; i++) begin
            imem_gnt    = 1'($urandom_range(0, 1));
            imem_rvalid = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
            pcsrc       = 1'($urandom_range(0, 1));
            pctarget    = $urandom & 32'hFFFF_FFFC;
            tick();
            if (imem_req !== 1'b0 || misalign_err !== 1'b1 || instr_valid !== 1'b0 || pc !== saved) stuck = 1'b0;
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0; pcsrc = 1'b0;
        tests_run++; if (!stuck) begin tests_failed++; $display("[TB] FAIL mis_terminal got exit expected stay"); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (misalign_err !== 1'b0 || pc !== 32'h0) begin tests_failed++; $display("[TB] FAIL mis_clear got err=%b pc=%h expected 0/0", misalign_err, pc); end
    endtask

    task automatic test_async_reset();
        bit found, stable;
        int n;
        logic [31:0] addr, data;
        tick();
        rst_n = 1'b1;
        n = 0;
        while (imem_req !== 1'b1 && n < 8) begin tick(); n++; end
        tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL ar_req got %b expected 1", imem_req); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0000_0013) begin tests_failed++; $display("[TB] FAIL ar_main got req=%b v=%b pc=%h i=%h expected reset", imem_req, instr_valid, pc, instr); end
        tests_run++; if (h_pc !== 32'hFFFF_FFFC || h_imem_addr !== 32'hFFFF_FFFC || h_pc_plus4 !== 32'h0 || h_imem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL ar_hi got pc=%h p4=%h req=%b expected fffffffc/0/0", h_pc, h_pc_plus4, h_imem_req); end
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
        tick();
        rst_n = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        tests_run++; if (instr_valid !== 1'b0 || h_instr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ar_stale got v=%b/%b expected 0", instr_valid, h_instr_valid); end
        data = $urandom;
        do_fetch(0, 0, data, 1'b0, found, stable, addr);
        tests_run++; if (h_instr_valid !== 1'b1 || h_instr !== data || h_pc !== 32'hFFFF_FFFC || h_pc_plus4 !== 32'h0) begin tests_failed++; $display("[TB] FAIL wrap_valid got v=%b pc=%h p4=%h expected 1/fffffffc/0", h_instr_valid, h_pc, h_pc_plus4); end
        retire(1'b0, 32'h0);
        tests_run++; if (h_imem_addr !== 32'h0 || h_imem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_addr got %h req=%b expected 0/1", h_imem_addr, h_imem_req); end
        tests_run++; if (imem_addr !== 32'h4) begin tests_failed++; $display("[TB] FAIL main_after_reset got %h expected 00000004", imem_addr); end
    endtask

    // Run the scenarios in order and report
    initial begin
        test_reset();
        test_first_fetch();
        test_sequential();
        test_redirect();
        test_backpressure();
        test_random();
        test_misalign();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
